// File: rtl/mod_sub.sv
// Sequential modular subtractor: M = (A - B) mod q with bit-serial operand reduction.
// Define MOD_SUB_PRE_REDUCED_EN when operands are already < q to skip the reduction states.
module mod_sub #(
   parameter int BIT_SIZE = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [BIT_SIZE-1:0] A,
   input  logic [BIT_SIZE-1:0] B,
   input  logic [BIT_SIZE-1:0] q,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [BIT_SIZE-1:0] M
);

`ifdef MOD_SUB_PRE_REDUCED_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SUB  = 3'd3,
      DONE = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RED_A = 3'd1,
      RED_B = 3'd2,
      SUB   = 3'd3,
      DONE  = 3'd4
   } state_t;
`endif

   state_t state_q, state_d;

   logic [BIT_SIZE-1:0] a_q, a_d;
   logic [BIT_SIZE-1:0] b_q, b_d;
   logic [BIT_SIZE-1:0] qm_q, qm_d;
   logic [BIT_SIZE-1:0] ra_q, ra_d;
   logic [BIT_SIZE-1:0] rb_q, rb_d;
   logic [BIT_SIZE-1:0] m_q, m_d;
   logic                err_q, err_d;
   logic [BIT_SIZE-1:0] sub_res;

`ifndef MOD_SUB_PRE_REDUCED_EN
   localparam int CW = (BIT_SIZE > 1) ? $clog2(BIT_SIZE) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(BIT_SIZE - 1);

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BIT_SIZE-1:0] r_q, r_d;
   logic                cur_bit;
   logic [BIT_SIZE:0]   r_shift;
   logic [BIT_SIZE-1:0] r_red;

   // r stays below q, so the shifted value needs only one extra bit
   always_comb begin
      cur_bit = (state_q == RED_A) ? a_q[cnt_q] : b_q[cnt_q];
      r_shift = {r_q, cur_bit};
      if (r_shift >= {1'b0, qm_q}) begin
         r_red = r_shift[BIT_SIZE-1:0] - qm_q;
      end else begin
         r_red = r_shift[BIT_SIZE-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         r_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         r_q   <= r_d;
      end
   end
`endif

   // rb < q, so q - rb never underflows and the sum stays below q
   always_comb begin
      if (ra_q >= rb_q) begin
         sub_res = ra_q - rb_q;
      end else begin
         sub_res = ra_q + (qm_q - rb_q);
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      qm_d    = qm_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      m_d     = m_q;
      err_d   = err_q;
`ifndef MOD_SUB_PRE_REDUCED_EN
      cnt_d   = cnt_q;
      r_d     = r_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = A;
               b_d   = B;
               qm_d  = q;
               err_d = 1'b0;
`ifndef MOD_SUB_PRE_REDUCED_EN
               cnt_d = CNT_TOP;
               r_d   = '0;
`endif
               if (q == '0) begin
                  err_d   = 1'b1;
                  m_d     = '0;
                  state_d = DONE;
               end else begin
`ifdef MOD_SUB_PRE_REDUCED_EN
                  ra_d    = A;
                  rb_d    = B;
                  state_d = SUB;
`else
                  state_d = RED_A;
`endif
               end
            end
         end
`ifndef MOD_SUB_PRE_REDUCED_EN
         RED_A: begin
            r_d   = r_red;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               ra_d    = r_red;
               r_d     = '0;
               cnt_d   = CNT_TOP;
               state_d = RED_B;
            end
         end
         RED_B: begin
            r_d   = r_red;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               rb_d    = r_red;
               r_d     = '0;
               cnt_d   = CNT_TOP;
               state_d = SUB;
            end
         end
`endif
         SUB: begin
            m_d     = sub_res;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         qm_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         m_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         qm_q    <= qm_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         m_q     <= m_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign err  = err_q;
   assign M    = m_q;

endmodule

// File: tb/tb_mod_sub.sv
// Self-checking bench for mod_sub: vector table, corner sequences, random ops vs model.
// Honours MOD_SUB_PRE_REDUCED_EN (shorter latency, operands kept below q).
module tb_mod_sub;
   localparam int W = 4;
`ifdef MOD_SUB_PRE_REDUCED_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 2 * W + 2;
`endif

   typedef struct {
      int a;
      int b;
      int qq;
      int m;
      int e;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A, B, q, M;
   logic         busy, done, err;

   int checks = 0;
   int failures = 0;
   int prev_m = 0;

   mod_sub #(.BIT_SIZE(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .B    (B),
      .q    (q),
      .busy (busy),
      .done (done),
      .err  (err),
      .M    (M)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic int model(input int a, input int b, input int qq);
      int d;
      d = (a % qq) - (b % qq);
      if (d < 0) d = d + qq;
      return d;
   endfunction

   // poke > 0 re-asserts start with a different A in cycle t+poke
   task automatic run_op(input int a, input int b, input int qq,
                         input int poke, input string tag);
      int exp_m, exp_e, lat;
      bit busy_ok;
      exp_e = (qq == 0) ? 1 : 0;
      exp_m = exp_e ? 0 : model(a, b, qq);
`ifdef MOD_SUB_PRE_REDUCED_EN
      if (qq != 0) begin
         assert (a < qq && b < qq)
         else $error("operand not below q");
      end
`endif
      A = W'(a);
      B = W'(b);
      q = W'(qq);
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      if (exp_e == 0) begin
         check({tag, "_err_clr"}, 32'(err), 32'd0);
         check({tag, "_m_hold"}, 32'(M), 32'(prev_m));
      end
      while (!done && lat < 40) begin
         if (!busy) busy_ok = 1'b0;
         if (lat == poke) begin
            start = 1'b1;
            A = ~A;
         end
         tick();
         start = 1'b0;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), exp_e ? 32'd1 : 32'(LAT));
      check({tag, "_m"}, 32'(M), 32'(exp_m));
      check({tag, "_err"}, 32'(err), 32'(exp_e));
      check({tag, "_busy"}, 32'(busy_ok & busy), 32'd1);
      prev_m = exp_m;
      tick();
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int qq, a, b;
      bit seen_done;
      rst = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      q = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_m", 32'(M), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);

`ifdef MOD_SUB_PRE_REDUCED_EN
      vecs.push_back('{1, 4, 7, 4, 0});
      vecs.push_back('{3, 3, 5, 0, 0});
      vecs.push_back('{0, 6, 7, 1, 0});
      vecs.push_back('{7, 2, 0, 0, 1});
      vecs.push_back('{4, 1, 5, 3, 0});
      vecs.push_back('{2, 0, 3, 2, 0});
      vecs.push_back('{0, 0, 1, 0, 0});
      vecs.push_back('{14, 0, 15, 14, 0});
`else
      vecs.push_back('{8, 3, 2, 1, 0});
      vecs.push_back('{5, 7, 3, 1, 0});
      vecs.push_back('{12, 6, 4, 2, 0});
      vecs.push_back('{3, 9, 11, 5, 0});
      vecs.push_back('{15, 15, 15, 0, 0});
      vecs.push_back('{7, 2, 0, 0, 1});
      vecs.push_back('{4, 1, 5, 3, 0});
      vecs.push_back('{9, 4, 1, 0, 0});
      vecs.push_back('{6, 6, 9, 0, 0});
      vecs.push_back('{15, 0, 15, 0, 0});
      vecs.push_back('{0, 1, 7, 6, 0});
`endif
      foreach (vecs[i]) begin
         check($sformatf("vec%0d_model", i),
               vecs[i].e ? 32'd0 : 32'(model(vecs[i].a, vecs[i].b, vecs[i].qq)),
               32'(vecs[i].m));
         run_op(vecs[i].a, vecs[i].b, vecs[i].qq, 0, $sformatf("vec%0d", i));
      end

`ifndef MOD_SUB_PRE_REDUCED_EN
      run_op(8, 3, 2, 3, "ignore_start");

      A = 4'd8;
      B = 4'd3;
      q = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_m", 32'(M), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      seen_done = 1'b0;
      repeat (12) begin
         if (done) seen_done = 1'b1;
         tick();
      end
      check("midrst_no_done", 32'(seen_done), 32'd0);
      prev_m = 0;
      run_op(12, 6, 4, 0, "after_rst");
`endif

      for (int i = 0; i < 60; i++) begin
         qq = $urandom_range(0, 15);
`ifdef MOD_SUB_PRE_REDUCED_EN
         if (qq > 0) begin
            a = $urandom_range(0, qq - 1);
            b = $urandom_range(0, qq - 1);
         end else begin
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
         end
`else
         a = $urandom_range(0, 15);
         b = $urandom_range(0, 15);
`endif
         run_op(a, b, qq, 0, $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mod_sub.md
Name: mod_sub

Overview:
Sequential modular subtractor: computes M = (A - B) mod q for unsigned BIT_SIZE-bit operands. It is the inverse operation to the team's modular adder and sits beside it in the modular-arithmetic datapath feeding the vedic multiplier.
- Both operands are first reduced mod q by a bit-serial restoring shift-subtract.
- A single subtract-with-correction step follows.
- Operands are latched on a start strobe; the result is reported with a one-cycle done pulse.

Parameters:
BIT_SIZE, 4, operand, modulus and result width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
A  input  BIT_SIZE  minuend, unsigned
B  input  BIT_SIZE  subtrahend, unsigned
q  input  BIT_SIZE  modulus, unsigned
busy  output  1  high whenever FSM is not in IDLE
done  output  1  one-cycle pulse; M and err are valid from this cycle
err  output  1  set with done when latched q == 0
M  output  BIT_SIZE  result (A - B) mod q, in range 0..q-1

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, M=0, busy=0, done=0, err=0, all internal registers cleared.
- Reset has priority over everything, including mid-operation; the in-flight operation is abandoned with no done pulse.
- States: IDLE, RED_A, RED_B, SUB, DONE.
- IDLE, start=1 at edge t: latch A, B and q; clear err; bit counter = BIT_SIZE-1; remainder r = 0.
  - Latched q == 0: go to DONE with M=0 and err=1. done is high in cycle t+1.
  - Otherwise go to RED_A.
- Start outside IDLE is ignored: no re-latch, no effect on the running operation.
- RED_A, one operand bit per cycle, MSB first: r' = {r, A[cnt]}.
  - Subtract q from r' if r' >= q.
  - r is BIT_SIZE+1 bits wide, so no overflow occurs.
  - Runs BIT_SIZE cycles. At cnt == 0 store ra = r (fits BIT_SIZE bits), reset r and cnt, go to RED_B.
- RED_B: identical processing on B, BIT_SIZE cycles, stores rb, then go to SUB.
- SUB (1 cycle):
  - ra >= rb: M = ra - rb.
  - Otherwise: M = ra + q - rb, computed at BIT_SIZE+1 bits, then truncated.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=1. Next state is IDLE.
- Latency: start sampled at edge t gives done high in cycle t + 2*BIT_SIZE + 2 (t+10 for BIT_SIZE=4).
- Throughput: a new start is accepted no earlier than the edge after DONE.
- M and err hold their value from DONE until the next accepted start, which clears err; M updates only at SUB.
- A, B and q may change freely after the start edge; only latched copies are used.
- Edge values:
  - q == 1: M = 0.
  - A == B: M = 0.
  - All-ones operands with q = 2^BIT_SIZE - 1: reduction maps them to 0.

Optional Feature:
MOD_SUB_PRE_REDUCED_EN
- Defined:
  - Operands are required to be < q already; RED_A and RED_B are removed from the FSM.
  - IDLE goes directly to SUB, and done is high at t+2.
  - ra and rb are the latched A and B.
  - q == 0 handling is unchanged.
  - Operands >= q give an undefined M. With this macro defined, the bench asserts that operands are < q.
- Undefined: full reduction path as described above.

Test Plan:
1. Reset held 2 cycles then released -> M=0, done=0, busy=0, err=0. Then A=8, B=3, q=2, start -> done at t+10 with M=1, err=0; busy high for cycles t+1..t+10.
2. A=5, B=7, q=3 -> M=1. A=12, B=6, q=4 -> M=2. A=3, B=9, q=11 (wrap) -> M=5. A=15, B=15, q=15 -> M=0.
3. q=0, A=7, B=2, start -> done at t+1 with err=1, M=0. Next start with A=4, B=1, q=5 -> err clears at start, M=3.
4. Start pulsed again at t+3 during an operation with different A -> ignored; first result M=1 (case 1 values) unchanged at t+10.
5. rst asserted at t+5 mid-RED_B -> IDLE next cycle, M=0, no done pulse. A new start then completes normally.
6. With MOD_SUB_PRE_REDUCED_EN defined: A=1, B=4, q=7 -> done at t+2 with M=4. Back-to-back starts on the cycle after each done pulse.
